defuzzifier: RTL
================

# defuzzifier

- Sequential back end of the fuzzy inference path.
- Consumes the aggregator's Q1.15 sums `S_w` (Σw) and `S_wg` (Σw·g/100) and produces the crisp output `G = S_wg·100 / S_w` as an integer percent 0..100.
- Uses a fixed-latency 8-step restoring divider behind a start/valid handshake. Degenerate inputs are resolved in one cycle.

## Interface

Parameters:
- `FRAC_W`, 15: fraction bits of the input Q1.15 format. Informational only; the datapath is fixed to 16-bit inputs.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `start`  input  1: request. Sampled only in IDLE.
- `S_w`  input  16: Σ weights, unsigned Q1.15. Latched on an accepted `start`.
- `S_wg`  input  16: Σ weight·grade, unsigned Q1.15. Latched on an accepted `start`.
- `G`  output  8: crisp output in percent, 0..100. Holds the last result.
- `g_valid`  output  1: one-cycle pulse when `G` is updated.
- `busy`  output  1: high from the accepted `start` until the result is issued.
- `w_zero`  output  1: last result came from `S_w == 0`. Updated together with `G`.
- `sat`  output  1: last result was clamped because `S_wg >= S_w`, with `S_w != 0`. Updated together with `G`.

## Operation

- States: IDLE, DIV, DONE.
- IDLE with `start == 1` at edge E0:
  - latch `D = S_w`;
  - latch `N = S_wg·100 + R`, where R is defined under Configuration;
  - set `busy = 1`.
- Degenerate cases, tested on the inputs at E0:
  - `S_w == 0`: go to DONE with `q = 0`, `w_zero = 1`, `sat = 0`.
  - else `S_wg >= S_w`: go to DONE with `q = 100`, `sat = 1`, `w_zero = 0`.
  - otherwise: go to DIV with `i = 7`, `rem = N`, `q = 0`.
- Widths:
  - `N` is 23 bits; its maximum is 100·32766 + 16383 < 2^22.
  - `rem` is 23 bits; `D<<i` is 23 bits.
  - The quotient is guaranteed ≤ 100, because `N < 101·D`.
- DIV, one step per edge, for i = 7 down to 0:
  - if `rem >= (D<<i)`: `rem -= D<<i`, `q[i] = 1`;
  - else `q[i] = 0`.
  - After the i = 0 step, go to DONE.
- DONE, one edge:
  - `G <= q[7:0]`;
  - `g_valid <= 1` for exactly one cycle;
  - `busy <= 0`;
  - latch `w_zero` and `sat` (both 0 for a normal divide);
  - go to IDLE.
- `start` while `busy` is ignored. Inputs are not re-sampled and nothing is queued.
- `S_w` and `S_wg` may change freely after E0; only the latched copies are used.
- `rst` at any time, including mid-DIV:
  - state returns to IDLE and the divide is abandoned;
  - `G = 0`, `g_valid = 0`, `busy = 0`, `w_zero = 0`, `sat = 0`;
  - internal `rem`, `q`, `i` are cleared.

## Timing

- Reset values: all outputs 0.
- Normal divide:
  - `start` accepted at E0; DIV steps at E1..E8; DONE update at E9.
  - `g_valid` is high during the cycle after E9; latency is 9 cycles.
- Degenerate case:
  - `start` at E0; DONE update at E1; `g_valid` high after E1; latency is 1 cycle.
- `busy` is high from after E0 until the edge that raises `g_valid`. It is low during the `g_valid` cycle.
- Back-to-back: a `start` sampled at the edge ending the `g_valid` cycle is accepted. The sustained rate is therefore one result per 10 cycles (normal) or per 2 cycles (degenerate).
- `G`, `w_zero` and `sat` are stable between updates.

## Configuration

- Macro `DEFUZZ_ROUND_EN`:
  - Defined: `R = S_w >> 1`, giving round-half-up to the nearest percent.
  - Undefined: `R = 0`, giving truncation.
- Degenerate handling, latency and handshake are identical in both builds.

## Test plan

- `S_w = 0x7FFF`, `S_wg = 16384`, `start` pulse → `G = 50`, `sat = 0`, `w_zero = 0`, `g_valid` 9 cycles after `start`, `busy` high for those 9 cycles. Holds in both builds.
- `S_w = 3`, `S_wg = 2` → `G = 67` with `DEFUZZ_ROUND_EN`, `G = 66` without; latency 9.
- `S_w = 0`, `S_wg = 500` → `G = 0`, `w_zero = 1`, `sat = 0`, `g_valid` 1 cycle after `start`. Then `S_w = 0x4000`, `S_wg = 0x7FFF` → `G = 100`, `sat = 1`, `w_zero = 0`, latency 1.
- `start` pulsed again at cycles 3 and 5 of a divide with `S_w = 0x7FFF`, `S_wg = 0x2000` → a single result `G = 25`, still at cycle 9. Changing the input ports mid-divide does not affect `G`.
- Assert `rst` at cycle 4 of a divide → all outputs 0 immediately and no `g_valid`. A new `start` after release with `S_w = 100`, `S_wg = 10` → `G = 10` at latency 9.
- Back-to-back: issue a new `start` in the `g_valid` cycle → accepted, with the second `g_valid` exactly 10 cycles after the first.

Source files
------------

// File: rtl/defuzzifier_if.sv
// Handshake and data bundle between the fuzzy aggregator and the defuzzifier.
// The master drives the request and Q1.15 sums; the slave returns the crisp percent result.
interface defuzzifier_if;
  logic        start;
  logic [15:0] S_w;
  logic [15:0] S_wg;
  logic [7:0]  G;
  logic        g_valid;
  logic        busy;
  logic        w_zero;
  logic        sat;

  modport master (
    output start, S_w, S_wg,
    input  G, g_valid, busy, w_zero, sat
  );

  modport slave (
    input  start, S_w, S_wg,
    output G, g_valid, busy, w_zero, sat
  );
endinterface

// File: rtl/defuzzifier.sv
// Crisp output G = S_wg*100 / S_w via an 8-step restoring divider; degenerate inputs finish in one cycle.
// Build option DEFUZZ_ROUND_EN: add S_w/2 to the dividend for round-half-up instead of truncation.
module defuzzifier #(
  parameter int FRAC_W = 15
) (
  input logic          clk,
  input logic          rst,
  defuzzifier_if.slave bus
);

  localparam int IN_W = FRAC_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IN_W-1:0]   d_q, d_d;
  logic [22:0]       rem_q, rem_d;
  logic [7:0]        q_q, q_d;
  logic [2:0]        i_q, i_d;
  logic [7:0]        g_q, g_d;
  logic              g_valid_q, g_valid_d;
  logic              busy_q, busy_d;
  logic              w_zero_q, w_zero_d;
  logic              sat_q, sat_d;
  logic              wz_pend_q, wz_pend_d;
  logic              sat_pend_q, sat_pend_d;

  logic [22:0]       round_term;
  logic [22:0]       n_in;
  logic [22:0]       shifted;

`ifdef DEFUZZ_ROUND_EN
  assign round_term = {8'd0, bus.S_w[15:1]};
`else
  assign round_term = '0;
`endif

  // Max dividend 65534*100 + 32767 still fits in 23 bits, and N < 101*D keeps q within 8 bits.
  assign n_in    = ({7'd0, bus.S_wg} * 23'd100) + round_term;
  assign shifted = {7'd0, d_q} << i_q;

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    rem_d      = rem_q;
    q_d        = q_q;
    i_d        = i_q;
    g_d        = g_q;
    g_valid_d  = 1'b0;
    busy_d     = busy_q;
    w_zero_d   = w_zero_q;
    sat_d      = sat_q;
    wz_pend_d  = wz_pend_q;
    sat_pend_d = sat_pend_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          d_d    = bus.S_w;
          rem_d  = n_in;
          i_d    = 3'd7;
          busy_d = 1'b1;
          if (bus.S_w == 16'd0) begin
            q_d        = 8'd0;
            wz_pend_d  = 1'b1;
            sat_pend_d = 1'b0;
            state_d    = DONE;
          end else if (bus.S_wg >= bus.S_w) begin
            q_d        = 8'd100;
            wz_pend_d  = 1'b0;
            sat_pend_d = 1'b1;
            state_d    = DONE;
          end else begin
            q_d        = 8'd0;
            wz_pend_d  = 1'b0;
            sat_pend_d = 1'b0;
            state_d    = DIV;
          end
        end
      end

      DIV: begin
        if (rem_q >= shifted) begin
          rem_d      = rem_q - shifted;
          q_d[i_q]   = 1'b1;
        end
        if (i_q == 3'd0) begin
          state_d = DONE;
        end else begin
          i_d = i_q - 3'd1;
        end
      end

      DONE: begin
        g_d       = q_q;
        g_valid_d = 1'b1;
        busy_d    = 1'b0;
        w_zero_d  = wz_pend_q;
        sat_d     = sat_pend_q;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      d_q        <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      i_q        <= '0;
      g_q        <= '0;
      g_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      w_zero_q   <= 1'b0;
      sat_q      <= 1'b0;
      wz_pend_q  <= 1'b0;
      sat_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      rem_q      <= rem_d;
      q_q        <= q_d;
      i_q        <= i_d;
      g_q        <= g_d;
      g_valid_q  <= g_valid_d;
      busy_q     <= busy_d;
      w_zero_q   <= w_zero_d;
      sat_q      <= sat_d;
      wz_pend_q  <= wz_pend_d;
      sat_pend_q <= sat_pend_d;
    end
  end

  assign bus.G       = g_q;
  assign bus.g_valid = g_valid_q;
  assign bus.busy    = busy_q;
  assign bus.w_zero  = w_zero_q;
  assign bus.sat     = sat_q;

endmodule
